// File: rtl/slot_occupancy_filter.sv
// ============================================================================
//  Module   : slot_occupancy_filter
//  Purpose  : Per-slot debounce of a time-multiplexed sensor stream.
//             Publishes committed occupancy, free count, full/empty and change events.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module slot_occupancy_filter #(
    parameter int NUM_SLOTS    = 4,
    parameter int SLOT_W       = 2,
    parameter int STABLE_COUNT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [SLOT_W-1:0]    sample_slot,
    input  logic                 sample_detected,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [SLOT_W:0]      free_count,
    output logic                 full,
    output logic                 empty,
    output logic                 change_valid,
    output logic [SLOT_W-1:0]    change_slot,
    output logic                 change_occupied,
    output logic                 sample_err
);

    localparam logic [1:0]       c_FREE      = 2'd0;
    localparam logic [1:0]       c_PEND_OCC  = 2'd1;
    localparam logic [1:0]       c_OCC       = 2'd2;
    localparam logic [1:0]       c_PEND_FREE = 2'd3;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_STABLE    = CNT_W'(STABLE_COUNT);
    localparam logic [SLOT_W:0]  c_NUM       = (SLOT_W+1)'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0][1:0]       state_q, state_d;
    logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]            occupied_q, occupied_d;
    logic [SLOT_W:0]                 free_count_q, free_count_d;
    logic                            full_q, full_d;
    logic                            empty_q, empty_d;
    logic                            change_valid_q, change_valid_d;
    logic [SLOT_W-1:0]               change_slot_q, change_slot_d;
    logic                            change_occupied_q, change_occupied_d;
    logic                            sample_err_q, sample_err_d;
    logic                            slot_in_range;
    logic [SLOT_W:0]                 pop;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        occupied_d        = occupied_q;
        change_valid_d    = 1'b0;
        change_slot_d     = change_slot_q;
        change_occupied_d = change_occupied_q;
        slot_in_range     = ({1'b0, sample_slot} < c_NUM);
        sample_err_d      = sample_valid && !slot_in_range;
        pop               = '0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sample_valid && slot_in_range && (sample_slot == SLOT_W'(i))) begin
                // A sample that agrees with the committed state always clears the count.
                case (state_q[i])
                    c_FREE, c_PEND_OCC: begin
                        if (!sample_detected) begin
                            state_d[i] = c_FREE;
                            cnt_d[i]   = '0;
                        end else if (((state_q[i] == c_FREE) ? c_ONE : cnt_q[i] + c_ONE) == c_STABLE) begin
                            state_d[i]        = c_OCC;
                            cnt_d[i]          = '0;
                            occupied_d[i]     = 1'b1;
                            change_valid_d    = 1'b1;
                            change_slot_d     = SLOT_W'(i);
                            change_occupied_d = 1'b1;
                        end else begin
                            state_d[i] = c_PEND_OCC;
                            cnt_d[i]   = (state_q[i] == c_FREE) ? c_ONE : cnt_q[i] + c_ONE;
                        end
                    end
                    default: begin
                        if (sample_detected) begin
                            state_d[i] = c_OCC;
                            cnt_d[i]   = '0;
                        end else if (((state_q[i] == c_OCC) ? c_ONE : cnt_q[i] + c_ONE) == c_STABLE) begin
                            state_d[i]        = c_FREE;
                            cnt_d[i]          = '0;
                            occupied_d[i]     = 1'b0;
                            change_valid_d    = 1'b1;
                            change_slot_d     = SLOT_W'(i);
                            change_occupied_d = 1'b0;
                        end else begin
                            state_d[i] = c_PEND_FREE;
                            cnt_d[i]   = (state_q[i] == c_OCC) ? c_ONE : cnt_q[i] + c_ONE;
                        end
                    end
                endcase
            end
        end

        // Count is derived from the next occupancy so all summary outputs move together.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pop = pop + {{SLOT_W{1'b0}}, occupied_d[i]};
        end
        free_count_d = c_NUM - pop;
        full_d       = (free_count_d == '0);
        empty_d      = (free_count_d == c_NUM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= {NUM_SLOTS{c_FREE}};
            cnt_q             <= '0;
            occupied_q        <= '0;
            free_count_q      <= c_NUM;
            full_q            <= 1'b0;
            empty_q           <= 1'b1;
            change_valid_q    <= 1'b0;
            change_slot_q     <= '0;
            change_occupied_q <= 1'b0;
            sample_err_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            occupied_q        <= occupied_d;
            free_count_q      <= free_count_d;
            full_q            <= full_d;
            empty_q           <= empty_d;
            change_valid_q    <= change_valid_d;
            change_slot_q     <= change_slot_d;
            change_occupied_q <= change_occupied_d;
            sample_err_q      <= sample_err_d;
        end
    end

    assign occupied        = occupied_q;
    assign free_count      = free_count_q;
    assign full            = full_q;
    assign empty           = empty_q;
    assign change_valid    = change_valid_q;
    assign change_slot     = change_slot_q;
    assign change_occupied = change_occupied_q;
    assign sample_err      = sample_err_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_occupancy_filter.sv
// ============================================================================
//  Module   : tb_slot_occupancy_filter
//  Purpose  : Directed vector bench for slot_occupancy_filter (4 slots, 3-bit slot index).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_slot_occupancy_filter;

    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_W       = 3;
    localparam int STABLE_COUNT = 4;
    localparam int CNT_W        = 3;

    logic                 clk;
    logic                 reset_n;
    logic                 sample_valid;
    logic [SLOT_W-1:0]    sample_slot;
    logic                 sample_detected;
    logic [NUM_SLOTS-1:0] occupied;
    logic [SLOT_W:0]      free_count;
    logic                 full;
    logic                 empty;
    logic                 change_valid;
    logic [SLOT_W-1:0]    change_slot;
    logic                 change_occupied;
    logic                 sample_err;

    typedef struct {
        logic       valid;
        logic [2:0] slot;
        logic       det;
        logic [3:0] occ;
        logic [3:0] free;
        logic       full;
        logic       empty;
        logic       cv;
        logic [2:0] cs;
        logic       co;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    slot_occupancy_filter #(
        .NUM_SLOTS   (NUM_SLOTS),
        .SLOT_W      (SLOT_W),
        .STABLE_COUNT(STABLE_COUNT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .sample_slot    (sample_slot),
        .sample_detected(sample_detected),
        .occupied       (occupied),
        .free_count     (free_count),
        .full           (full),
        .empty          (empty),
        .change_valid   (change_valid),
        .change_slot    (change_slot),
        .change_occupied(change_occupied),
        .sample_err     (sample_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [2:0] s, input logic d,
                       input logic [3:0] occ, input logic [3:0] fr, input logic fu,
                       input logic em, input logic cv, input logic [2:0] cs,
                       input logic co, input logic er);
        vec_t t;
        t.valid = v; t.slot = s; t.det = d; t.occ = occ; t.free = fr; t.full = fu;
        t.empty = em; t.cv = cv; t.cs = cs; t.co = co; t.err = er;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] occ, input logic [3:0] fr,
                           input logic fu, input logic em, input logic cv,
                           input logic [2:0] cs, input logic co, input logic er);
        chk("occupied", idx, {4'd0, occupied}, {4'd0, occ});
        chk("free_count", idx, {4'd0, free_count}, {4'd0, fr});
        chk("full", idx, {7'd0, full}, {7'd0, fu});
        chk("empty", idx, {7'd0, empty}, {7'd0, em});
        chk("change_valid", idx, {7'd0, change_valid}, {7'd0, cv});
        chk("change_slot", idx, {5'd0, change_slot}, {5'd0, cs});
        chk("change_occupied", idx, {7'd0, change_occupied}, {7'd0, co});
        chk("sample_err", idx, {7'd0, sample_err}, {7'd0, er});
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic d);
        @(negedge clk);
        sample_valid    = v;
        sample_slot     = s;
        sample_detected = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Slot 2 commits on its 4th detection, then a quiet cycle drops the pulse.
        for (int k = 0; k < 3; k++) add(1, 2, 1, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        add(1, 2, 1, 4'b0100, 3, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 4'b0100, 3, 0, 0, 0, 2, 1, 0);
        // Slot 1 glitch: 1,1,1,0 restarts, then 1,1,1 pending, 4th commits.
        for (int k = 0; k < 3; k++) add(1, 1, 1, 4'b0100, 3, 0, 0, 0, 2, 1, 0);
        add(1, 1, 0, 4'b0100, 3, 0, 0, 0, 2, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 1, 4'b0100, 3, 0, 0, 0, 2, 1, 0);
        add(1, 1, 1, 4'b0110, 2, 0, 0, 1, 1, 1, 0);
        // Interleaved slot 0 / slot 3: commits land on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 1, 4'b0110, 2, 0, 0, 0, 1, 1, 0);
            add(1, 3, 1, 4'b0110, 2, 0, 0, 0, 1, 1, 0);
        end
        add(1, 0, 1, 4'b0111, 1, 0, 0, 1, 0, 1, 0);
        add(1, 3, 1, 4'b1111, 0, 1, 0, 1, 3, 1, 0);
        // Release slot 0.
        for (int k = 0; k < 3; k++) add(1, 0, 0, 4'b1111, 0, 1, 0, 0, 3, 1, 0);
        add(1, 0, 0, 4'b1110, 1, 0, 0, 1, 0, 0, 0);
        // Slot 3 release glitch rejected.
        for (int k = 0; k < 3; k++) add(1, 3, 0, 4'b1110, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 4'b1110, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 4'b1110, 1, 0, 0, 0, 0, 0, 0);
        // Out-of-range slot 5 and slot 4: error pulse only.
        add(1, 5, 1, 4'b1110, 1, 0, 0, 0, 0, 0, 1);
        add(0, 5, 1, 4'b1110, 1, 0, 0, 0, 0, 0, 0);
        add(1, 4, 0, 4'b1110, 1, 0, 0, 0, 0, 0, 1);
        add(1, 4, 0, 4'b1110, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 4'b1110, 1, 0, 0, 0, 0, 0, 0);

        reset_n         = 1'b0;
        sample_valid    = 1'b0;
        sample_slot     = '0;
        sample_detected = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_all(-1, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0);
        chk_all(-2, 4'b0000, 4, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].slot, vecs[i].det);
            chk_all(i, vecs[i].occ, vecs[i].free, vecs[i].full, vecs[i].empty,
                    vecs[i].cv, vecs[i].cs, vecs[i].co, vecs[i].err);
        end

        // Asynchronous reset clears committed state without waiting for a clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all(100, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset after 2 of 4 samples discards the partial count.
        drive(1, 1, 1);
        drive(1, 1, 1);
        chk_all(101, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_all(102, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1);
            chk_all(103 + k, 4'b0000, 4, 0, 1, 0, 0, 0, 0);
        end
        drive(1, 1, 1);
        chk_all(106, 4'b0010, 3, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0);
        chk_all(107, 4'b0010, 3, 0, 0, 0, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
